// File: rtl/mac_dot_seq_pkg.sv
// Shared types and constants for the mac_dot_seq operand sequencer.
// The downstream MAC is a two-stage pipeline on 8-bit operands.
package mac_pkg;

    localparam int OP_W         = 8;
    localparam int MAC_PIPE_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac_dot_seq_op_fifo.sv
// First-word-fall-through FIFO holding packed {A,B} operand pairs.
// Pushes into a full FIFO and pops from an empty one are ignored.
module op_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [2*OP_W-1:0] wdata,
    input  logic              pop,
    output logic [2*OP_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [2*OP_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_dot_seq.sv
// Operand sequencer feeding a two-stage MAC: buffers (A,B) pairs and runs
// clear / issue / drain for a dot-product job of programmable length.
module mac_dot_seq
    import mac_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [OP_W-1:0]  in_A,
    input  logic [OP_W-1:0]  in_B,
    output logic             in_rdy,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    output logic [OP_W-1:0]  A,
    output logic [OP_W-1:0]  B,
    output logic             en,
    output logic             clr,
    output logic             busy,
    output logic             done
);

    localparam int DCW = $clog2(MAC_PIPE_LAT + 1);

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_next;
    logic [DCW-1:0]    dcnt;
    logic [2*OP_W-1:0] head;
    logic              full;
    logic              empty;
    logic              pop;

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_vld),
        .wdata ({in_A, in_B}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign in_rdy   = !full;
    assign busy     = (state != IDLE);
    assign pop      = (state == RUN) && !empty;
    assign cnt_next = cnt + LEN_W'(1);

    // The first DRAIN cycle may still carry the final en; drain counting
    // starts only once en has dropped so the MAC gets its full latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            A     <= '0;
            B     <= '0;
            en    <= 1'b0;
            clr   <= 1'b0;
            done  <= 1'b0;
            len   <= '0;
            cnt   <= '0;
            dcnt  <= '0;
        end else begin
            en   <= 1'b0;
            clr  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len   <= vec_len;
                        cnt   <= '0;
                        clr   <= 1'b1;
                        state <= CLR;
                    end
                end
                CLR: begin
                    dcnt  <= '0;
                    state <= (len != '0) ? RUN : DRAIN;
                end
                RUN: begin
                    if (pop) begin
                        A   <= head[2*OP_W-1:OP_W];
                        B   <= head[OP_W-1:0];
                        en  <= 1'b1;
                        cnt <= cnt_next;
                        if (cnt_next == len) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!en) begin
                        if (dcnt == DCW'(MAC_PIPE_LAT - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            dcnt <= dcnt + DCW'(1);
                        end
                    end
                end
                DONE: begin
                    dcnt  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural two-stage MAC attached
// so each job's final accumulator value can be checked at done.
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic [7:0]  in_A;
    logic [7:0]  in_B;
    logic        in_rdy;
    logic        start;
    logic [15:0] vec_len;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        en;
    logic        clr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_prod;
    logic        m_pv;
    logic [31:0] accum;

    int          w_clr, w_clr_cyc, w_en, w_first_en, w_last_en, w_done_cyc;
    logic [31:0] w_acc;
    bit          w_overlap, w_timeout;
    logic [7:0]  w_a [16];
    logic [7:0]  w_b [16];

    always #5 clk = ~clk;

    mac_dot_seq #(
        .DEPTH (8),
        .LEN_W (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_A    (in_A),
        .in_B    (in_B),
        .in_rdy  (in_rdy),
        .start   (start),
        .vec_len (vec_len),
        .A       (A),
        .B       (B),
        .en      (en),
        .clr     (clr),
        .busy    (busy),
        .done    (done)
    );

    // Reference MAC: product registered on the en edge, accumulated one edge later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prod <= '0;
            m_pv   <= 1'b0;
            accum  <= '0;
        end else if (clr) begin
            m_pv  <= 1'b0;
            accum <= '0;
        end else begin
            m_pv   <= en;
            m_prod <= {8'b0, A} * {8'b0, B};
            if (m_pv) accum <= accum + {16'b0, m_prod};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        in_vld = 1'b1;
        in_A   = a;
        in_B   = b;
        step();
        in_vld = 1'b0;
    endtask

    task automatic start_job(input logic [15:0] n);
        start   = 1'b1;
        vec_len = n;
        step();
        start   = 1'b0;
    endtask

    // Observes one job from its clr cycle (cycle 0) up to done or budget.
    task automatic watch_job(input int budget);
        bit seen = 0;
        w_clr = 0; w_clr_cyc = -1; w_en = 0; w_first_en = -1; w_last_en = -1;
        w_done_cyc = -1; w_acc = '0; w_overlap = 0; w_timeout = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            if (en && clr) w_overlap = 1;
            if (clr) begin w_clr++; w_clr_cyc = c; end
            if (en) begin
                if (w_en < 16) begin w_a[w_en] = A; w_b[w_en] = B; end
                if (w_first_en < 0) w_first_en = c;
                w_last_en = c;
                w_en++;
            end
            if (done) begin
                seen = 1; w_done_cyc = c; w_acc = accum;
            end else begin
                step();
            end
        end
        if (!seen) w_timeout = 1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_vld = 1'b0; in_A = '0; in_B = '0; start = 1'b0; vec_len = '0;
        #1;
        checks++; if ({en, clr, done, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ctrl got %b want 0000", {en, clr, done, busy}); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_rdy got %b want 1", in_rdy); end
        checks++; if ({A, B} !== 16'h0) begin errors++; $display("[TB] FAIL reset_ab got %h want 0000", {A, B}); end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) push_pair(8'd3, 8'd4);
        start_job(16'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        watch_job(40);
        checks++; if (w_timeout) begin errors++; $display("[TB] FAIL basic_timeout got no done want done"); end
        checks++; if (w_clr !== 1) begin errors++; $display("[TB] FAIL basic_clr_cycles got %0d want 1", w_clr); end
        checks++; if (w_en !== 4) begin errors++; $display("[TB] FAIL basic_en_cycles got %0d want 4", w_en); end
        checks++; if (w_last_en - w_first_en !== 3) begin errors++; $display("[TB] FAIL basic_en_span got %0d want 3", w_last_en - w_first_en); end
        checks++; if (w_done_cyc - w_last_en !== 3) begin errors++; $display("[TB] FAIL basic_done_lat got %0d want 3", w_done_cyc - w_last_en); end
        checks++; if (w_acc !== 32'd48) begin errors++; $display("[TB] FAIL basic_accum got %0d want 48", w_acc); end
        checks++; if (w_overlap) begin errors++; $display("[TB] FAIL basic_en_clr_overlap got 1 want 0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_bubbles();
        fork
            begin
                start_job(16'd3);
                watch_job(60);
            end
            begin
                push_pair(8'd2, 8'd5);
                step(); step();
                push_pair(8'd7, 8'd7);
                step(); step();
                push_pair(8'd255, 8'd255);
            end
        join
        checks++; if (w_timeout) begin errors++; $display("[TB] FAIL bubble_timeout got no done want done"); end
        checks++; if (w_en !== 3) begin errors++; $display("[TB] FAIL bubble_en_cycles got %0d want 3", w_en); end
        checks++; if (w_last_en - w_first_en <= 2) begin errors++; $display("[TB] FAIL bubble_gaps got span %0d want >2", w_last_en - w_first_en); end
        checks++; if (w_acc !== 32'd65084) begin errors++; $display("[TB] FAIL bubble_accum got %0d want 65084", w_acc); end
    endtask

    task automatic test_fifo_full();
        int accepted = 0;
        for (int k = 1; k <= 10; k++) begin
            in_vld = 1'b1; in_A = 8'(k); in_B = 8'(k + 10);
            if (in_rdy) accepted++;
            step();
        end
        in_vld = 1'b0;
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_in_rdy got %b want 0", in_rdy); end
        checks++; if (accepted !== 8) begin errors++; $display("[TB] FAIL full_accepted got %0d want 8", accepted); end
        start_job(16'd8);
        watch_job(60);
        checks++; if (w_en !== 8) begin errors++; $display("[TB] FAIL full_en_cycles got %0d want 8", w_en); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_a[i] !== 8'(i + 1) || w_b[i] !== 8'(i + 11)) begin
                errors++; $display("[TB] FAIL full_order[%0d] got %0d,%0d want %0d,%0d", i, w_a[i], w_b[i], i + 1, i + 11);
            end
        end
        checks++; if (w_acc !== 32'd564) begin errors++; $display("[TB] FAIL full_accum got %0d want 564", w_acc); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL full_drained_rdy got %b want 1", in_rdy); end
        // Pairs 9 and 10 must be gone: the next job stalls until a fresh pair arrives.
        fork
            begin
                start_job(16'd1);
                watch_job(40);
            end
            begin
                repeat (6) step();
                push_pair(8'd6, 8'd7);
            end
        join
        checks++; if (w_en !== 1 || w_first_en <= 4) begin errors++; $display("[TB] FAIL full_no_stale got en=%0d at %0d want 1 at >4", w_en, w_first_en); end
        checks++; if (w_acc !== 32'd42) begin errors++; $display("[TB] FAIL full_stall_accum got %0d want 42", w_acc); end
    endtask

    task automatic test_back_to_back();
        start_job(16'd0);
        watch_job(20);
        checks++; if (w_timeout || w_en !== 0) begin errors++; $display("[TB] FAIL len0_en got en=%0d timeout=%0d want 0,0", w_en, w_timeout); end
        checks++; if (w_done_cyc - w_clr_cyc !== 3) begin errors++; $display("[TB] FAIL len0_done_lat got %0d want 3", w_done_cyc - w_clr_cyc); end
        checks++; if (w_acc !== 32'd0) begin errors++; $display("[TB] FAIL len0_accum got %0d want 0", w_acc); end
        push_pair(8'd1, 8'd1);
        push_pair(8'd2, 8'd2);
        fork
            begin
                start_job(16'd2);
                watch_job(30);
            end
            begin
                repeat (3) step();
                start = 1'b1; vec_len = 16'd7;
                step();
                start = 1'b0;
            end
        join
        checks++; if (w_en !== 2) begin errors++; $display("[TB] FAIL b2b_en_cycles got %0d want 2", w_en); end
        checks++; if (w_acc !== 32'd5) begin errors++; $display("[TB] FAIL b2b_accum got %0d want 5", w_acc); end
        repeat (3) step();
        checks++; if (busy !== 1'b0 || clr !== 1'b0) begin errors++; $display("[TB] FAIL b2b_not_queued got busy=%b clr=%b want 0,0", busy, clr); end
        push_pair(8'd1, 8'd1);
        push_pair(8'd2, 8'd2);
        start_job(16'd2);
        watch_job(30);
        checks++; if (w_timeout || w_acc !== 32'd5) begin errors++; $display("[TB] FAIL restart_accum got %0d want 5", w_acc); end
    endtask

    task automatic test_async_reset();
        int seen_en = 0;
        int saw_done = 0;
        for (int k = 1; k <= 5; k++) push_pair(8'(k), 8'd2);
        start_job(16'd5);
        for (int c = 0; c < 20 && seen_en < 2; c++) begin
            if (en) seen_en++;
            if (seen_en < 2) step();
        end
        checks++; if (seen_en !== 2) begin errors++; $display("[TB] FAIL rst_reach_run got %0d en want 2", seen_en); end
        rst_n = 1'b0;
        #1;
        checks++; if ({en, clr, done, busy} !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_ctrl got %b want 0000", {en, clr, done, busy}); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_rdy got %b want 1", in_rdy); end
        for (int c = 0; c < 3; c++) begin
            step();
            if (done) saw_done++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done) saw_done++;
        end
        checks++; if (saw_done !== 0) begin errors++; $display("[TB] FAIL rst_no_done got %0d want 0", saw_done); end
        fork
            begin
                start_job(16'd1);
                watch_job(40);
            end
            begin
                repeat (4) step();
                push_pair(8'd9, 8'd9);
            end
        join
        checks++; if (w_timeout || w_en !== 1) begin errors++; $display("[TB] FAIL rst_new_job_en got %0d want 1", w_en); end
        checks++; if (w_acc !== 32'd81) begin errors++; $display("[TB] FAIL rst_new_job_accum got %0d want 81", w_acc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_fifo_full();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
Operand sequencer that sits directly upstream of mult_accum_gated. It buffers incoming (A,B) operand pairs in a small FIFO and runs a dot-product job of programmable length. For each job it issues one clr cycle, then one en cycle per operand pair, then waits out the MAC's two-stage pipeline. It pulses done when the MAC accumulator holds the final sum.

Parameters:
DEPTH, 8, FIFO entries (power of 2, ≥2)
LEN_W, 16, width of job length / issue counter

Ports:
clk  in  1  system clock (same clock as MAC)
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  operand pair valid
in_A  in  8  operand A
in_B  in  8  operand B
in_rdy  out  1  FIFO can accept (= !full)
start  in  1  begin job; sampled only in IDLE
vec_len  in  LEN_W  number of pairs in job; latched on accepted start
A  out  8  registered operand to MAC
B  out  8  registered operand to MAC
en  out  1  registered; MAC consumes A,B this cycle
clr  out  1  registered; MAC clears accumulator
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; MAC accum final

Behaviour:
- Reset (async, rst_n=0): state=IDLE; A=B=0, en=0, clr=0, done=0; FIFO emptied (pointers/count=0, in_rdy=1); len and cnt=0. Reset mid-job abandons the job with no done.
- FIFO: push when in_vld&&in_rdy, in any state (prefetch allowed). Pop only in RUN when !empty. Simultaneous push+pop when not full: count unchanged. When full, in_rdy=0 and in_vld is ignored. Pointers wrap modulo DEPTH. Order preserved.
- FSM states: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE: start=1 -> latch len=vec_len, cnt=0, go to CLR. Other inputs ignored.
- CLR: clr=1 for exactly one cycle, en=0. Next state: RUN if len≠0, else DRAIN.
- RUN: each cycle with !empty, pop; at the next edge A,B <= popped pair, en <= 1, cnt++. Cycles with an empty FIFO give en=0 (bubble), with no limit. When the pop making cnt==len occurs, go to DRAIN; no further pops.
- DRAIN: exactly 2 cycles with en=0 and clr=0, counted from the cycle after the last en=1. The MAC registers the product on the edge ending the en cycle and accumulates on the following edge.
- DONE: done=1 for one cycle, then IDLE. len=0 job: clr, 2 DRAIN cycles, done, giving accum=0.
- Outputs en/clr/A/B/done come straight from flops; none depend combinationally on inputs. en and clr are never high in the same cycle. A/B hold their last value when en=0.
- start while busy is ignored, and is not queued.
- Width: cnt and len are LEN_W bits; max job 2^LEN_W−1 pairs.

Decomposition:
- Package mac_pkg: state enum typedef (IDLE, CLR, RUN, DRAIN, DONE), MAC_PIPE_LAT=2 constant, operand width constant OP_W=8.
- One sub-module, op_fifo: synchronous FIFO of {A,B} with DEPTH parameter, full/empty flags and the same clk/rst_n. The FSM and issue registers stay in mac_dot_seq.

Test Plan:
- Basic job: preload 4 pairs (3,4); start with vec_len=4. Expect clr 1 cycle, en high 4 consecutive cycles, done exactly 3 cycles after the last en rises (2 DRAIN + 1). Connected MAC accum=48 when done=1.
- Bubbles: vec_len=3; feed pairs (2,5),(7,7),(255,255) with 2 idle cycles between in_vld pulses. Expect en to have gaps, 3 total en cycles, and accum=10+49+65025=65084 at done.
- FIFO full: hold start low and push 10 pairs with DEPTH=8. Expect in_rdy=0 after 8 accepted and pairs 9–10 not stored. A job with vec_len=8 then consumes them in order (check A/B sequence).
- len=0 and back-to-back: start vec_len=0 gives clr, then done 3 cycles later with accum=0. A start during busy of the next job (vec_len=2, pairs (1,1),(2,2)) is ignored. A restart after done gives accum=5 and shows no carry-over.
- Async reset mid-RUN: assert rst_n=0 after 2 of 5 en cycles. Expect en/clr/done=0 immediately, in_rdy=1, FIFO empty, and no done. After release, a new job with vec_len=1 and pair (9,9) gives accum=81.
